// File: rtl/alu_pkg.sv
// Shared ALU definitions for the shared-ALU arbiter and its clients.
// Provides:
//   - the eleven legal 4-bit ALU function codes
//   - is_legal_alufn() membership test
//   - bit positions of the {cf,zf,vf,sf} flag vector
//   - FSM state encoding for the arbiter (IDLE/EXEC/RESP)
//   - alu_op_t, the latched operation bundle
package alu_pkg;

    localparam logic [3:0] ALUFN_ADD  = 4'b0000;
    localparam logic [3:0] ALUFN_SUB  = 4'b0001;
    localparam logic [3:0] ALUFN_PASS = 4'b0011;
    localparam logic [3:0] ALUFN_OR   = 4'b0100;
    localparam logic [3:0] ALUFN_AND  = 4'b0101;
    localparam logic [3:0] ALUFN_XOR  = 4'b0111;
    localparam logic [3:0] ALUFN_SRL  = 4'b1000;
    localparam logic [3:0] ALUFN_SLL  = 4'b1001;
    localparam logic [3:0] ALUFN_SRA  = 4'b1010;
    localparam logic [3:0] ALUFN_SLT  = 4'b1101;
    localparam logic [3:0] ALUFN_SLTU = 4'b1111;

    // Flag vector layout: {cf, zf, vf, sf}
    localparam int unsigned FLAG_CF = 3;
    localparam int unsigned FLAG_ZF = 2;
    localparam int unsigned FLAG_VF = 1;
    localparam int unsigned FLAG_SF = 0;

    // Arbiter FSM encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    typedef struct packed {
        logic [3:0]  fn;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  shamt;
    } alu_op_t;

    function automatic logic is_legal_alufn(input logic [3:0] fn);
        logic legal;
        case (fn)
            ALUFN_ADD, ALUFN_SUB, ALUFN_PASS, ALUFN_OR, ALUFN_AND,
            ALUFN_XOR, ALUFN_SRL, ALUFN_SLL, ALUFN_SRA, ALUFN_SLT,
            ALUFN_SLTU: legal = 1'b1;
            default:    legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu_share_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter.
// Ports:
//   req   in  NREQ  request vector
//   ptr   in  IDW   highest-priority index (must be < NREQ)
//   grant out NREQ  one-hot grant, zero when no request
//   idx   out IDW   encoded index of the granted requester
//   any   out 1     at least one request present
module rr_arbiter #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IDW  = 3
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx,
    output logic            any
);

    int unsigned p;
    logic        found;

    // Two ordered passes (indices >= ptr, then indices < ptr) give the
    // wrap-around search without any modulo arithmetic, so NREQ need not
    // be a power of two.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        p     = 32'(ptr);
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!found && req[i] && (i >= p)) begin
                grant[i] = 1'b1;
                idx      = IDW'(i);
                found    = 1'b1;
            end
        end
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!found && req[i] && (i < p)) begin
                grant[i] = 1'b1;
                idx      = IDW'(i);
                found    = 1'b1;
            end
        end
        any = found;
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one external 32-bit ALU between NREQ requesters.
// A round-robin grant in IDLE latches the winner's operation, the ALU is
// driven for one EXEC cycle, and its result/flags are returned on a single
// tagged response channel held in RESP until accepted.
// Ports:
//   clk, rst                 clock, async active-high reset
//   req_valid/req_ready      per-requester handshake (ready is one-hot or 0)
//   req_alufn/a/b/shamt      packed per-requester operation payloads
//   alu_a/b/fn/shamt         operands to the external ALU (registered)
//   alu_r, alu_flags         ALU result and {cf,zf,vf,sf}
//   rsp_valid/rsp_ready      response handshake
//   rsp_id/result/flags      served requester, captured result and flags
//   rsp_illegal              latched alufn was not a legal code
//   busy                     FSM not in IDLE
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IDW  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [4*NREQ-1:0] req_alufn,
    input  logic [32*NREQ-1:0] req_a,
    input  logic [32*NREQ-1:0] req_b,
    input  logic [5*NREQ-1:0] req_shamt,
    output logic [31:0]       alu_a,
    output logic [31:0]       alu_b,
    output logic [3:0]        alu_fn,
    output logic [4:0]        alu_shamt,
    input  logic [31:0]       alu_r,
    input  logic [3:0]        alu_flags,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [31:0]       rsp_result,
    output logic [3:0]        rsp_flags,
    output logic              rsp_illegal,
    output logic              busy
);

    logic [1:0]      state;
    logic [IDW-1:0]  rr_ptr;
    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  gnt_idx;
    logic            gnt_any;
    alu_op_t         op_sel;
    alu_op_t         op_q;
    logic [IDW-1:0]  id_q;
    logic [31:0]     result_q;
    logic [3:0]      flags_q;
    logic            illegal_q;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (gnt),
        .idx   (gnt_idx),
        .any   (gnt_any)
    );

    // Grant is only offered in IDLE; gating with rst keeps ready low for
    // the whole reset pulse, not just after the first reset edge.
    assign req_ready = (state == ST_IDLE && !rst) ? gnt : '0;

    always_comb begin
        op_sel = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                op_sel.fn    = req_alufn[i*4 +: 4];
                op_sel.a     = req_a[i*32 +: 32];
                op_sel.b     = req_b[i*32 +: 32];
                op_sel.shamt = req_shamt[i*5 +: 5];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            rr_ptr    <= '0;
            op_q      <= '0;
            id_q      <= '0;
            result_q  <= '0;
            flags_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (gnt_any) begin
                        op_q   <= op_sel;
                        id_q   <= gnt_idx;
                        rr_ptr <= (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
                        state  <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    result_q  <= alu_r;
                    flags_q   <= alu_flags;
                    illegal_q <= !is_legal_alufn(op_q.fn);
                    state     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign alu_a       = op_q.a;
    assign alu_b       = op_q.b;
    assign alu_fn      = op_q.fn;
    assign alu_shamt   = op_q.shamt;

    assign rsp_valid   = (state == ST_RESP);
    assign rsp_id      = id_q;
    assign rsp_result  = result_q;
    assign rsp_flags   = flags_q;
    assign rsp_illegal = illegal_q;
    assign busy        = (state != ST_IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter (NREQ=3 to exercise a
// non-power-of-two wrap). A behavioural ALU stands in for the external ALU.
module tb_alu_share_arbiter;

    localparam int unsigned NREQ = 3;
    localparam int unsigned IDW  = 2;

    logic                 clk;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [4*NREQ-1:0]    req_alufn;
    logic [32*NREQ-1:0]   req_a;
    logic [32*NREQ-1:0]   req_b;
    logic [5*NREQ-1:0]    req_shamt;
    logic [31:0]          alu_a, alu_b, alu_r;
    logic [3:0]           alu_fn, alu_flags;
    logic [4:0]           alu_shamt;
    logic                 rsp_valid, rsp_ready;
    logic [IDW-1:0]       rsp_id;
    logic [31:0]          rsp_result;
    logic [3:0]           rsp_flags;
    logic                 rsp_illegal, busy;

    logic [31:0] pa [NREQ];
    logic [31:0] pb [NREQ];
    logic [3:0]  pfn[NREQ];
    logic [4:0]  psh[NREQ];

    int n_chk  = 0;
    int n_fail = 0;
    int m_ptr  = 0;

    alu_share_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_alufn(req_alufn), .req_a(req_a), .req_b(req_b), .req_shamt(req_shamt),
        .alu_a(alu_a), .alu_b(alu_b), .alu_fn(alu_fn), .alu_shamt(alu_shamt),
        .alu_r(alu_r), .alu_flags(alu_flags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags),
        .rsp_illegal(rsp_illegal), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        req_alufn = '0; req_a = '0; req_b = '0; req_shamt = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_alufn[i*4 +: 4]  = pfn[i];
            req_a[i*32 +: 32]    = pa[i];
            req_b[i*32 +: 32]    = pb[i];
            req_shamt[i*5 +: 5]  = psh[i];
        end
    end

    // Behavioural ALU: returns {cf,zf,vf,sf,result}
    function automatic logic [35:0] alu_model(input logic [3:0] fn, input logic [31:0] a,
                                              input logic [31:0] b, input logic [4:0] sh);
        logic [32:0] w;
        logic [31:0] r;
        logic cf, vf;
        cf = 1'b0; vf = 1'b0; r = '0; w = '0;
        case (fn)
            4'd0:  begin w = {1'b0, a} + {1'b0, b}; r = w[31:0]; cf = w[32];
                         vf = (a[31] == b[31]) && (r[31] != a[31]); end
            4'd1:  begin w = {1'b0, a} + {1'b0, ~b} + 33'd1; r = w[31:0]; cf = w[32];
                         vf = (a[31] != b[31]) && (r[31] != a[31]); end
            4'd3:  r = b;
            4'd4:  r = a | b;
            4'd5:  r = a & b;
            4'd7:  r = a ^ b;
            4'd8:  r = a >> sh;
            4'd9:  r = a << sh;
            4'd10: r = $unsigned($signed(a) >>> sh);
            4'd13: r = {31'd0, $signed(a) < $signed(b)};
            4'd15: r = {31'd0, a < b};
            default: r = '0;
        endcase
        return {cf, (r == 32'd0), vf, r[31], r};
    endfunction

    always_comb {alu_flags, alu_r} = alu_model(alu_fn, alu_a, alu_b, alu_shamt);

    function automatic bit model_illegal(input logic [3:0] fn);
        int legal[11] = '{0, 1, 3, 4, 5, 7, 8, 9, 10, 13, 15};
        foreach (legal[k]) if (int'(fn) == legal[k]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int model_grant(input logic [NREQ-1:0] mask, input int ptr);
        for (int k = 0; k < NREQ; k++) begin
            int c;
            c = (ptr + k) % NREQ;
            if (mask[c]) return c;
        end
        return -1;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issues one operation from the requesters in mask and follows it through
    // to the response handshake; ends at the first IDLE cycle afterwards.
    task automatic run_op(input logic [NREQ-1:0] mask, input int hold, input bit keep,
                          output int g);
        int cnt;
        logic [35:0] ev;
        logic [NREQ-1:0] eg;
        logic [3:0] efn;
        logic [31:0] ea, eb;
        logic [4:0] esh;
        req_valid = mask;
        rsp_ready = (hold == 0);
        #1;
        cnt = 0;
        while (req_ready == '0 && cnt < 8) begin
            @(negedge clk); #1; cnt++;
        end
        g  = model_grant(mask, m_ptr);
        eg = (g >= 0) ? (NREQ'(1) << g) : '0;
        check("grant", 64'(req_ready), 64'(eg));
        check("grant_wait", 64'(cnt), 64'd0);
        if (req_ready == '0 || g < 0) return;
        efn = pfn[g]; ea = pa[g]; eb = pb[g]; esh = psh[g];
        ev  = alu_model(efn, ea, eb, esh);
        m_ptr = (g + 1) % NREQ;
        @(negedge clk); #1;
        if (!keep) req_valid[g] = 1'b0;
        check("exec_busy", 64'(busy), 64'd1);
        check("exec_rsp_valid", 64'(rsp_valid), 64'd0);
        check("exec_ready", 64'(req_ready), 64'd0);
        check("exec_alu_ops", {27'd0, alu_fn, alu_shamt, alu_a ^ alu_b},
                              {27'd0, efn, esh, ea ^ eb});
        check("exec_alu_a", 64'(alu_a), 64'(ea));
        @(negedge clk); #1;
        check("rsp_valid", 64'(rsp_valid), 64'd1);
        check("rsp_id", 64'(rsp_id), 64'(g));
        check("rsp_result", 64'(rsp_result), 64'(ev[31:0]));
        check("rsp_flags", 64'(rsp_flags), 64'(ev[35:32]));
        check("rsp_illegal", 64'(rsp_illegal), 64'(model_illegal(efn)));
        for (int k = 0; k < hold; k++) begin
            @(negedge clk); #1;
            check("hold_valid", 64'(rsp_valid), 64'd1);
            check("hold_result", 64'(rsp_result), 64'(ev[31:0]));
            check("hold_ready", 64'(req_ready), 64'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk); #1;
        check("post_busy", 64'(busy), 64'd0);
        check("post_rsp_valid", 64'(rsp_valid), 64'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;
        m_ptr = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        rst = 1'b1;
        rsp_ready = 1'b0;
        req_valid = '1;
        for (int i = 0; i < NREQ; i++) begin
            pa[i] = 32'd0; pb[i] = 32'd0; pfn[i] = 4'd0; psh[i] = 5'd0;
        end

        // Reset state with requests pending
        repeat (2) @(negedge clk);
        #1;
        check("rst_ready", 64'(req_ready), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_rsp", {rsp_valid, rsp_illegal, rsp_flags, rsp_id, rsp_result}, 64'd0);
        check("rst_alu", {alu_a, alu_fn, alu_shamt}, 64'd0);
        req_valid = '0;
        rst = 1'b0;
        m_ptr = 0;
        @(negedge clk); #1;

        // ADD 5+7 on requester 0
        pfn[0] = 4'b0000; pa[0] = 32'd5; pb[0] = 32'd7;
        run_op(3'b001, 0, 1'b0, g);
        check("add_result", 64'(rsp_result), 64'd12);
        check("add_zf", 64'(rsp_flags[2]), 64'd0);
        check("add_id", 64'(rsp_id), 64'd0);

        // SUB 3-3 on requester 1
        pfn[1] = 4'b0001; pa[1] = 32'd3; pb[1] = 32'd3;
        run_op(3'b010, 0, 1'b0, g);
        check("sub_result", 64'(rsp_result), 64'd0);
        check("sub_flags", 64'(rsp_flags), 64'hC);
        check("sub_id", 64'(rsp_id), 64'd1);

        // Contention from reset: expect 0,1,0,1
        do_reset();
        @(negedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            run_op(3'b011, 0, 1'b1, g);
            check("cont_order", 64'(rsp_id), 64'(i % 2));
        end
        req_valid = '0;

        // Backpressure: SLL 1<<4 on requester 0 with requester 1 waiting
        pfn[0] = 4'b1001; pa[0] = 32'd1; pb[0] = 32'd0; psh[0] = 5'd4;
        run_op(3'b011, 5, 1'b1, g);
        check("bp_result", 64'(rsp_result), 64'd16);
        check("bp_next_grant", 64'(req_ready), 64'b010);
        run_op(3'b010, 0, 1'b0, g);

        // Illegal code on requester 2
        pfn[2] = 4'b0010; pa[2] = 32'd9; pb[2] = 32'd9;
        run_op(3'b100, 0, 1'b0, g);
        check("ill_flag", 64'(rsp_illegal), 64'd1);
        check("ill_result", 64'(rsp_result), 64'd0);

        // Reset during EXEC
        pfn[0] = 4'b0000; pa[0] = 32'd1; pb[0] = 32'd1;
        req_valid = 3'b001;
        rsp_ready = 1'b1;
        #1;
        check("mid_grant", 64'(req_ready), 64'b001);
        @(negedge clk); #1;
        check("mid_in_exec", 64'(busy), 64'd1);
        req_valid = 3'b011;
        #1;
        rst = 1'b1;
        #1;
        check("mid_busy", 64'(busy), 64'd0);
        check("mid_rsp_valid", 64'(rsp_valid), 64'd0);
        check("mid_ready", 64'(req_ready), 64'd0);
        req_valid = '0;
        @(negedge clk); #1;
        rst = 1'b0;
        m_ptr = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            check("mid_no_stale", {62'd0, rsp_valid, busy}, 64'd0);
        end
        run_op(3'b011, 0, 1'b0, g);
        check("mid_first_grant", 64'(rsp_id), 64'd0);
        req_valid = '0;

        // Randomized operations
        for (int n = 0; n < 40; n++) begin
            logic [NREQ-1:0] mask;
            mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            for (int i = 0; i < NREQ; i++) begin
                pa[i]  = $urandom;
                pb[i]  = ($urandom_range(0, 3) == 0) ? pa[i] : $urandom;
                pfn[i] = 4'($urandom_range(0, 15));
                psh[i] = 5'($urandom_range(0, 31));
            end
            run_op(mask, $urandom_range(0, 2), 1'b0, g);
            req_valid = '0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
